ctr_encoder: RTL

CTR_ENCODER -- requirements
Module: ctr_encoder

---
 rtl/ctr_encoder_pkg.sv | 57 +++++
 rtl/ctr_encoder_if.sv | 46 ++++
 rtl/ctr_encoder_fifo.sv | 48 ++++
 rtl/ctr_encoder.sv | 74 +++++++
 4 files changed

// File: rtl/ctr_encoder_pkg.sv
// Shared constants, control bundle and class decoder for ctr_encoder.
// Optional CTR_ENCODER_ERR_CNT_EN adds an illegal-bundle counter to the top.
package ctr_encoder_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALU_MEM    = 2'b00;
  localparam logic [1:0] ALU_BRANCH = 2'b01;
  localparam logic [1:0] ALU_FUNCT  = 2'b10;

  typedef enum logic [2:0] {
    R, LW, SW, BEQ, J, ILLEGAL
  } instrClass_t;

  typedef struct packed {
    logic       regDst;
    logic       aluSrc;
    logic       memToReg;
    logic       regWrite;
    logic       memRead;
    logic       memWrite;
    logic       branch;
    logic [1:0] aluOp;
    logic       jump;
  } ctrl_t;

  function automatic logic hit(
    ctrl_t c, logic [9:0] v, logic [9:0] m
  );
    return (c & m) == v;
  endfunction

  // sw and beq ignore regDst and memToReg
  function automatic instrClass_t classify(ctrl_t c);
    instrClass_t cls;
    cls = ILLEGAL;
    unique case (1'b1)
      hit(c, {7'b1001000, ALU_FUNCT, 1'b0},
          10'h3FF):           cls = R;
      hit(c, {7'b0111100, ALU_MEM, 1'b0},
          10'h3FF):           cls = LW;
      hit(c, {7'b0100010, ALU_MEM, 1'b0},
          10'b0101111111):    cls = SW;
      hit(c, {7'b0000001, ALU_BRANCH, 1'b0},
          10'b0101111111):    cls = BEQ;
      hit(c, {7'b0000000, ALU_MEM, 1'b1},
          10'h3FF):           cls = J;
      default:                cls = ILLEGAL;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/ctr_encoder_if.sv
// Bundle-in / instruction-word-out handshake bus of ctr_encoder.
// Master drives the bundle and consumer ready; slave is the encoder.
interface ctr_encoder_if;

  logic        inValid;
  logic        inReady;
  logic        regDst;
  logic        aluSrc;
  logic        memToReg;
  logic        regWrite;
  logic        memRead;
  logic        memWrite;
  logic        branch;
  logic        jump;
  logic [1:0]  aluOp;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [5:0]  funct;
  logic [15:0] imm;
  logic [25:0] target;
  logic        outValid;
  logic        outReady;
  logic [31:0] instr;
  logic [5:0]  opCode;
  logic        illegal;

  modport master (
    output inValid, regDst, aluSrc, memToReg,
    output regWrite, memRead, memWrite, branch,
    output jump, aluOp, rs, rt, rd, funct,
    output imm, target, outReady,
    input  inReady, outValid, instr, opCode,
    input  illegal
  );

  modport slave (
    input  inValid, regDst, aluSrc, memToReg,
    input  regWrite, memRead, memWrite, branch,
    input  jump, aluOp, rs, rt, rd, funct,
    input  imm, target, outReady,
    output inReady, outValid, instr, opCode,
    output illegal
  );

endinterface

// File: rtl/ctr_encoder_fifo.sv
// Two-entry 32-bit synchronous FIFO, valid/ready on both sides.
// No bypass: a full FIFO refuses a push even while popping.
module ctr_encoder_fifo (
  input  logic        clk,
  input  logic        reset,
  input  logic        inValid,
  output logic        inReady,
  input  logic [31:0] inData,
  output logic        outValid,
  input  logic        outReady,
  output logic [31:0] outData
);

  logic [31:0] mem [2];
  logic        wrPtr;
  logic        rdPtr;
  logic [1:0]  count;
  logic        push;
  logic        pop;

  assign inReady  = count < 2'd2;
  assign outValid = count != 2'd0;
  assign push     = inValid && inReady;
  assign pop      = outValid && outReady;
  assign outData  = mem[rdPtr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wrPtr  <= 1'b0;
      rdPtr  <= 1'b0;
      count  <= 2'd0;
      mem[0] <= '0;
      mem[1] <= '0;
    end else begin
      if (push) begin
        mem[wrPtr] <= inData;
        wrPtr      <= ~wrPtr;
      end
      if (pop) rdPtr <= ~rdPtr;
      unique case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ctr_encoder.sv
// Classifies a MIPS control bundle and queues the encoded word.
// CTR_ENCODER_ERR_CNT_EN adds a saturating errCnt output.
module ctr_encoder
  import ctr_encoder_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  ctr_encoder_if.slave bus
`ifdef CTR_ENCODER_ERR_CNT_EN
  ,
  output logic [7:0] errCnt
`endif
);

  ctrl_t       ctrl;
  instrClass_t cls;
  logic [31:0] word;
  logic        take;
  logic        push;
  logic        illegalQ;

  assign ctrl = {
    bus.regDst, bus.aluSrc, bus.memToReg,
    bus.regWrite, bus.memRead, bus.memWrite,
    bus.branch, bus.aluOp, bus.jump
  };
  assign cls = classify(ctrl);

  always_comb begin
    word = '0;
    unique case (cls)
      R:   word = {OP_RTYPE, bus.rs, bus.rt,
                   bus.rd, 5'b0, bus.funct};
      LW:  word = {OP_LW, bus.rs, bus.rt, bus.imm};
      SW:  word = {OP_SW, bus.rs, bus.rt, bus.imm};
      BEQ: word = {OP_BEQ, bus.rs, bus.rt, bus.imm};
      J:   word = {OP_J, bus.target};
      default: word = '0;
    endcase
  end

  // Illegal bundles are consumed but never enqueued
  assign take = bus.inValid && bus.inReady;
  assign push = take && (cls != ILLEGAL);

  always_ff @(posedge clk) begin
    if (reset) illegalQ <= 1'b0;
    else       illegalQ <= take && (cls == ILLEGAL);
  end

  assign bus.illegal = illegalQ;
  assign bus.opCode  = bus.instr[31:26];

  ctr_encoder_fifo uFifo (
    .clk      (clk),
    .reset    (reset),
    .inValid  (push),
    .inReady  (bus.inReady),
    .inData   (word),
    .outValid (bus.outValid),
    .outReady (bus.outReady),
    .outData  (bus.instr)
  );

`ifdef CTR_ENCODER_ERR_CNT_EN
  always_ff @(posedge clk) begin
    if (reset)
      errCnt <= 8'd0;
    else if (illegalQ && errCnt != 8'hFF)
      errCnt <= errCnt + 8'd1;
  end
`endif

endmodule
